// File: rtl/ping_pong_drain_ctrl.sv
// rtl/ping_pong_drain_ctrl.sv - two-bank result capture with valid/ready drain
// Write side fills one bank while the read side streams the other bank downstream.
module ping_pong_drain_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int COL_Y      = 2,
    parameter int NUM_ROWS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_done,
    input  logic [DATA_WIDTH-1:0] acc_data,
    output logic                  acc_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] out_row_idx,
    output logic                  frame_done,
    output logic [1:0]            bank_full,
    output logic                  overflow
);

    localparam int AW = $clog2(COL_Y);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(COL_Y - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;

    logic [DATA_WIDTH-1:0] r_bank0 [COL_Y];
    logic [DATA_WIDTH-1:0] r_bank1 [COL_Y];

    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic [AW-1:0]         r_wr_addr;
    logic                  r_rd_bank;
    logic [AW-1:0]         r_rd_addr;
    logic [RW-1:0]         r_row_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_frame_done;
    logic                  r_overflow;

    logic                  w_wr_fire;
    logic                  w_wr_last;
    logic [1:0]            w_full_set;
    logic [1:0]            w_full_clr;
    logic                  w_hs;
    logic                  w_rd_last;
    logic                  w_load;
    logic                  w_rd_done;
    logic                  w_valid_nxt;
    logic [AW-1:0]         w_rd_addr_nxt;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_frame_end;

    assign acc_ready  = ~r_full[r_wr_bank];
    assign w_wr_fire  = acc_done && acc_ready;
    assign w_wr_last  = (r_wr_addr == LAST_ADDR);
    assign w_hs       = r_out_valid && out_ready;
    assign w_rd_last  = (r_rd_addr == LAST_ADDR);

    // Set and clear always hit different bits: writes only fill empty banks, reads only drain full ones.
    assign w_full_set[0] = w_wr_fire && w_wr_last && !r_wr_bank;
    assign w_full_set[1] = w_wr_fire && w_wr_last &&  r_wr_bank;
    assign w_full_clr[0] = w_rd_done && !r_rd_bank;
    assign w_full_clr[1] = w_rd_done &&  r_rd_bank;

    assign w_frame_end = w_rd_done && (r_row_cnt == LAST_ROW);
    assign w_rd_word   = r_rd_bank ? r_bank1[w_rd_addr_nxt] : r_bank0[w_rd_addr_nxt];

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            if (r_wr_bank) begin
                r_bank1[r_wr_addr] <= acc_data;
            end else begin
                r_bank0[r_wr_addr] <= acc_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_wr_addr <= '0;
                end else begin
                    r_wr_addr <= r_wr_addr + AW'(1);
                end
            end else if (acc_done) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_rd_done     = 1'b0;
        w_valid_nxt   = r_out_valid;
        w_rd_addr_nxt = r_rd_addr;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt   = RD_STREAM;
                    w_load        = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_rd_addr_nxt = '0;
                end
            end
            RD_STREAM: begin
                if (w_hs) begin
                    if (w_rd_last) begin
                        w_state_nxt = RD_IDLE;
                        w_rd_done   = 1'b1;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_load        = 1'b1;
                        w_valid_nxt   = 1'b1;
                        w_rd_addr_nxt = r_rd_addr + AW'(1);
                    end
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank    <= 1'b0;
            r_rd_addr    <= '0;
            r_row_cnt    <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_addr    <= w_rd_addr_nxt;
            r_out_valid  <= w_valid_nxt;
            r_frame_done <= w_frame_end;
            if (w_load) begin
                r_out_data <= w_rd_word;
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
                r_row_cnt <= w_frame_end ? '0 : r_row_cnt + RW'(1);
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_valid && w_rd_last;
    assign out_row_idx = r_row_cnt;
    assign frame_done  = r_frame_done;
    assign bank_full   = r_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_ping_pong_drain_ctrl.sv
// tb/tb_ping_pong_drain_ctrl.sv - directed and random checks against a queue-based model
module tb_ping_pong_drain_ctrl;

    localparam int DW = 64;
    localparam int CY = 2;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acc_done;
    logic [DW-1:0] acc_data;
    logic          acc_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_last;
    logic [0:0]    out_row_idx;
    logic          frame_done;
    logic [1:0]    bank_full;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ping_pong_drain_ctrl #(.DATA_WIDTH(DW), .COL_Y(CY), .NUM_ROWS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_done   (acc_done),
        .acc_data   (acc_data),
        .acc_ready  (acc_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_row_idx(out_row_idx),
        .frame_done (frame_done),
        .bank_full  (bank_full),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: completed rows form a FIFO, each tagged with the bank it landed in.
    logic [DW-1:0] m_partial [$];
    logic [DW-1:0] m_rows    [$];
    logic          m_row_bank[$];
    logic          m_wr_par;
    logic          m_valid;
    int            m_idx;
    int            m_row;
    logic          m_frame_done;
    logic          m_overflow;
    int            m_nfull;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_partial.delete();
            m_rows.delete();
            m_row_bank.delete();
            m_wr_par     = 1'b0;
            m_valid      = 1'b0;
            m_idx        = 0;
            m_row        = 0;
            m_frame_done = 1'b0;
            m_overflow   = 1'b0;
        end else begin
            m_nfull      = m_row_bank.size();
            m_frame_done = 1'b0;
            if (m_valid) begin
                if (out_ready) begin
                    if (m_idx == CY - 1) begin
                        repeat (CY) void'(m_rows.pop_front());
                        void'(m_row_bank.pop_front());
                        m_valid = 1'b0;
                        m_idx   = 0;
                        if (m_row == NR - 1) begin
                            m_row        = 0;
                            m_frame_done = 1'b1;
                        end else begin
                            m_row++;
                        end
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_nfull > 0) begin
                m_valid = 1'b1;
                m_idx   = 0;
            end
            if (acc_done) begin
                if (m_nfull < 2) begin
                    m_partial.push_back(acc_data);
                    if (m_partial.size() == CY) begin
                        foreach (m_partial[i]) m_rows.push_back(m_partial[i]);
                        m_row_bank.push_back(m_wr_par);
                        m_wr_par = ~m_wr_par;
                        m_partial.delete();
                    end
                end else begin
                    m_overflow = 1'b1;
                end
            end
        end
    end

    logic [1:0] e_full;
    always @(negedge clk) begin
        if (rst_n) begin
            e_full = 2'b00;
            foreach (m_row_bank[i]) e_full[m_row_bank[i]] = 1'b1;
            chk("m_acc_ready",  acc_ready,  m_row_bank.size() < 2);
            chk("m_out_valid",  out_valid,  m_valid);
            chk("m_bank_full",  bank_full,  e_full);
            chk("m_overflow",   overflow,   m_overflow);
            chk("m_frame_done", frame_done, m_frame_done);
            chk("m_row_idx",    out_row_idx, m_row[0]);
            chk("m_out_last",   out_last,   m_valid && (m_idx == CY - 1));
            if (m_valid) chk("m_out_data", out_data, m_rows[m_idx]);
        end
    end

    task automatic step(input logic d, input logic [DW-1:0] v, input logic r);
        @(negedge clk);
        acc_done  = d;
        acc_data  = v;
        out_ready = r;
    endtask

    task automatic check_reset_vals();
        chk("rst_acc_ready",  acc_ready,   1);
        chk("rst_out_valid",  out_valid,   0);
        chk("rst_out_data",   out_data,    0);
        chk("rst_out_last",   out_last,    0);
        chk("rst_row_idx",    out_row_idx, 0);
        chk("rst_frame_done", frame_done,  0);
        chk("rst_bank_full",  bank_full,   0);
        chk("rst_overflow",   overflow,    0);
    endtask

    task automatic scenario_basic();
        step(1, 64'h11, 1);
        step(1, 64'h22, 1);
        step(0, 0, 1);
        chk("s1_full_after_w2", bank_full, 2'b01);
        chk("s1_no_valid_yet",  out_valid, 0);
        step(0, 0, 1);
        chk("s1_valid0", out_valid, 1);
        chk("s1_data0",  out_data,  64'h11);
        chk("s1_last0",  out_last,  0);
        step(0, 0, 1);
        chk("s1_data1",  out_data,    64'h22);
        chk("s1_last1",  out_last,    1);
        chk("s1_row1",   out_row_idx, 0);
        step(0, 0, 1);
        chk("s1_valid_end", out_valid,   0);
        chk("s1_row_after", out_row_idx, 1);
    endtask

    logic [DW-1:0] rec [5];
    logic [DW-1:0] exp_seq [5];

    initial begin
        rst_n = 1'b0; acc_done = 1'b0; acc_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        step(0, 0, 1);

        scenario_basic();

        step(1, 64'hA1, 0);
        step(1, 64'hA2, 0);
        step(1, 64'hA3, 0);
        step(1, 64'hA4, 0);
        step(0, 0, 0);
        chk("s2_full11",    bank_full, 2'b11);
        chk("s2_not_ready", acc_ready, 0);
        chk("s2_no_ovf",    overflow,  0);
        step(1, 64'hA5, 0);
        step(0, 0, 0);
        chk("s2_ovf",       overflow,  1);
        chk("s2_full_kept", bank_full, 2'b11);
        exp_seq[0] = 64'hA1; exp_seq[1] = 64'hA2; exp_seq[2] = 64'h0;
        exp_seq[3] = 64'hA3; exp_seq[4] = 64'hA4;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1);
            rec[k] = out_valid ? out_data : 64'h0;
            if (k == 0) chk("s2_row_first", out_row_idx, 1);
            if (k == 2) begin
                chk("s2_frame_done", frame_done, 1);
                chk("s2_ready_back", acc_ready,  1);
            end
        end
        for (int k = 0; k < 5; k++) chk($sformatf("s2_seq%0d", k), rec[k], exp_seq[k]);

        step(1, 64'hB0, 1);
        step(1, 64'hB1, 1);
        step(0, 0, 1);
        chk("ov_full_a", bank_full, 2'b10);
        step(1, 64'hB2, 1);
        chk("ov_data_b0", out_data, 64'hB0);
        step(1, 64'hB3, 1);
        chk("ov_data_b1", out_data, 64'hB1);
        chk("ov_full_b",  bank_full, 2'b10);
        step(0, 0, 1);
        chk("ov_full_swap", bank_full, 2'b01);
        chk("ov_idle",      out_valid, 0);
        step(0, 0, 1);
        chk("ov_valid_b2", out_valid, 1);
        chk("ov_data_b2",  out_data,  64'hB2);
        repeat (4) step(0, 0, 1);

        step(1, 64'hC0, 0);
        step(1, 64'hC1, 0);
        step(1, 64'hC2, 0);
        step(0, 0, 0);
        chk("rd_mid_valid", out_valid, 1);
        chk("rd_mid_data",  out_data,  64'hC0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        scenario_basic();

        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 9) < 6);
        end
        step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ping_pong_drain_ctrl.md
# ping_pong_drain_ctrl

Output-side counterpart of the Multi-Head Attention input ping-pong controller. It captures result words produced by the matmul/accumulator wrapper, one word per `acc_done` pulse, into two internal register banks. It drains each full bank to the next stage over a valid/ready stream. Writing into one bank proceeds while the other bank is being drained, so result collection and downstream consumption overlap.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of one accumulated result word.
- `COL_Y`, 2, words per bank (one result row of blocks); must be ≥ 2.
- `NUM_ROWS`, 4, banks (rows) per frame; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `acc_done`  in  1  write strobe, one word per high cycle.
- `acc_data`  in  DATA_WIDTH  result word, sampled when `acc_done`=1.
- `acc_ready`  out  1  write bank has space (`~full[wr_bank]`).
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  DATA_WIDTH  drained word.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  current word is the last word of its bank.
- `out_row_idx`  out  $clog2(NUM_ROWS) (min 1)  row index of the bank being drained.
- `frame_done`  out  1  one-cycle pulse after the last word of row `NUM_ROWS-1` is accepted.
- `bank_full`  out  2  full flags, bit i = bank i.
- `overflow`  out  1  sticky; set by a dropped write.

## Operation
- Storage: `bank0[COL_Y]`, `bank1[COL_Y]`, each DATA_WIDTH wide. Banks are not reset; flags and pointers are.

Write side:
- State: `wr_bank` (1b), `wr_addr` (0..COL_Y-1).
- Accepted write = `acc_done && acc_ready`. It stores `acc_data` at `bank[wr_bank][wr_addr]`.
  - If `wr_addr==COL_Y-1`: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_addr`.
  - Otherwise: increment `wr_addr`.
- `acc_done && !acc_ready`: word dropped, `overflow` set, pointers unchanged.

Read side:
- FSM `RD_IDLE`, `RD_STREAM`. State: `rd_bank`, `rd_addr`, `row_cnt`.
- `RD_IDLE`: if `full[rd_bank]`, load `out_data = bank[rd_bank][0]`, `out_valid=1`, `rd_addr=0`, go to `RD_STREAM`.
- `RD_STREAM`: on handshake `out_valid && out_ready`:
  - Not last: `rd_addr+1`, load the next word with no bubble.
  - Last (`rd_addr==COL_Y-1`): clear `full[rd_bank]`, toggle `rd_bank`, `out_valid=0`, go to `RD_IDLE`. Then:
    - If `row_cnt==NUM_ROWS-1`: `row_cnt=0` and pulse `frame_done`.
    - Otherwise: increment `row_cnt`.
- `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- `out_last = (rd_addr==COL_Y-1) && out_valid`. `out_row_idx = row_cnt`.

## Timing
- Reset values:
  - `acc_ready=1`, `out_valid=0`, `out_data=0`, `out_last=0`, `out_row_idx=0`.
  - `frame_done=0`, `bank_full=2'b00`, `overflow=0`.
  - `wr_bank=0`, `rd_bank=0`, FSM = `RD_IDLE`.
- All outputs are registered, except `acc_ready` and `out_last`, which are decoded from registers.
- Latency from the last write to first output: the last write is accepted at edge E0 and `full` is visible after E0. `out_valid` rises after E1, i.e. 2 edges from the write.
- Drain rate: 1 word/cycle while `out_ready=1`. There is exactly one idle cycle between consecutive banks.
- Set/clear of different bank bits in the same cycle are independent; both take effect.
- Write and read cannot target the same full flag simultaneously: write only sets an empty bank, read only clears a full one.
- Both banks full: `acc_ready=0` until the drain of `rd_bank` completes. `acc_ready` returns high the cycle after the last handshake.
- Reset mid-stream: asynchronous clear of all state. Partial bank contents are discarded and no `frame_done` is produced.

## Test plan
- COL_Y=2, NUM_ROWS=2, `out_ready=1`: write 0x11 and 0x22 on consecutive cycles.
  - Expect `bank_full=01` after write 2.
  - Expect `out_valid` 2 edges after the last write, with `out_data` 0x11 then 0x22.
  - Expect `out_last` on 0x22 and `out_row_idx=0`.
- Four words 0xA1–0xA4 back-to-back with `out_ready=0`:
  - Expect `bank_full=11` and `acc_ready=0`.
  - A fifth `acc_done` drops its word and sets `overflow=1`.
  - After `out_ready` rises, expect output order A1, A2, (one bubble), A3, A4.
- Backpressure: toggle `out_ready` 1,0,0,1 during a drain. `out_data` must hold stable while stalled and no word may be duplicated or lost.
- NUM_ROWS=2: drain two banks. Expect `out_row_idx` 0 then 1, and a `frame_done` pulse one cycle wide after the second `out_last` handshake. `row_cnt` then wraps to 0.
- Overlap: write bank 1 while bank 0 drains, so that bank 1 completes in the same cycle as the last read of bank 0.
  - Expect `bank_full` 01→10 in one edge.
  - Bank 1 output starts after one idle cycle.
- Assert `rst_n=0` mid-drain, off the clock edge. All outputs must go to their reset values immediately. After release, a fresh write sequence must behave as in the first scenario.
